m1_frame_sequencer: RTL and testbench

//  Timing master and serializer for one M1 telemetry channel, directly downstream of the

---
 rtl/m1_frame_sequencer_pkg.sv | 19 +
 rtl/m1_frame_sequencer_bit_divider.sv | 34 +++
 rtl/m1_frame_sequencer.sv | 146 ++++++++++++++
 tb/tb_m1_frame_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/m1_frame_sequencer_pkg.sv
// Shared constants and state encoding for the M1 telemetry channel
// (frame sequencer, word filler, phrase buffer).
package m1_frame_sequencer_pkg;

  localparam int M1_WORD_BITS  = 12;
  localparam int M1_PHRASE_LEN = 128;
  localparam int M1_GROUP_LEN  = 32;
  localparam int PTR_W         = 7;
  localparam int GRP_W         = 5;
  localparam int BIT_W         = $clog2(M1_WORD_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } seq_state_t;

endpackage

// File: rtl/m1_frame_sequencer_bit_divider.sv
// Serial bit-rate divider: divCnt runs 0..CLK_DIV-1 while enabled, tick marks the
// last clock of a bit and bit_strobe flags the first clock of the following bit.
module m1_bit_divider #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic start,
  input  logic halt,
  output logic tick,
  output logic bit_strobe
);

  localparam int DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0] div_cnt;

  assign tick = en && (div_cnt == DIV_W'(CLK_DIV - 1));

  // Divider counter and bit-start pulse; start covers bit 0 of the first word,
  // halt suppresses the pulse after the final bit of a stream.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt    <= '0;
      bit_strobe <= 1'b0;
    end else begin
      bit_strobe <= start | (tick & ~halt);
      if (!en || tick) div_cnt <= '0;
      else             div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/m1_frame_sequencer.sv
// M1 frame sequencer: walks word slots 0..PHRASE_LEN-1 and phrases 0..GROUP_LEN-1,
// fetches one word per slot from the filler and serializes it MSB first.
//
// Fetch handshake: buf_get_word is a one-clock request. buf_rd_pointer/cnt_grp are
// updated with the strobe and held until the next strobe; the filler registers the
// word, so data_word is valid from the clock after the strobe until the next strobe.
module m1_frame_sequencer
  import m1_frame_sequencer_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int PHRASE_LEN = M1_PHRASE_LEN,
  parameter int GROUP_LEN  = M1_GROUP_LEN
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic [M1_WORD_BITS-1:0] data_word,
  output logic                    buf_get_word,
  output logic [PTR_W-1:0]        buf_rd_pointer,
  output logic [GRP_W-1:0]        cnt_grp,
  output logic                    ser_out,
  output logic                    bit_strobe,
  output logic                    frame_sync,
  output logic                    busy,
  output logic [1:0]              fsm_state
);

  seq_state_t               state;
  logic [M1_WORD_BITS-1:0]  shreg;
  logic [BIT_W-1:0]         bit_cnt;
  logic [PTR_W-1:0]         cur_ptr;
  logic [GRP_W-1:0]         cur_grp;
  logic                     pend;
  logic                     prime_cnt;

  logic                     tick;
  logic                     shifting;
  logic                     last_slot;
  logic [PTR_W-1:0]         nxt_ptr;
  logic [GRP_W-1:0]         nxt_grp;
  logic                     prefetch;
  logic                     word_end;
  logic                     stop_now;
  logic                     prime_load;
  logic                     load_now;
  logic                     committed;

  // Slot arithmetic for the word after the one currently shifting.
  assign last_slot = (cur_ptr == PTR_W'(PHRASE_LEN - 1));
  assign nxt_ptr   = last_slot ? '0 : cur_ptr + 1'b1;
  assign nxt_grp   = !last_slot ? cur_grp :
                     (cur_grp == GRP_W'(GROUP_LEN - 1)) ? '0 : cur_grp + 1'b1;

  assign shifting   = (state == RUN) || (state == DRAIN);
  // A draining channel does not fetch word 0 of the next phrase.
  assign prefetch   = shifting && tick && (bit_cnt == BIT_W'(1)) &&
                      !((state == DRAIN) && !run && last_slot);
  assign word_end   = shifting && tick && (bit_cnt == BIT_W'(M1_WORD_BITS - 1));
  // No word waiting at the end of a word only happens after a suppressed fetch.
  assign stop_now   = word_end && (state == DRAIN) && !pend;
  assign prime_load = (state == PRIME) && prime_cnt;
  assign load_now   = prime_load || (word_end && !stop_now);
  // Once the last-slot fetch point has passed without a fetch the stop is final.
  assign committed  = (bit_cnt >= BIT_W'(2)) && !pend;

  assign ser_out   = shreg[M1_WORD_BITS-1];
  assign busy      = (state != IDLE);
  assign fsm_state = state;

  m1_bit_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .clk        (clk),
    .reset      (reset),
    .en         (shifting),
    .start      (prime_load),
    .halt       (stop_now),
    .tick       (tick),
    .bit_strobe (bit_strobe)
  );

  // Sequencer FSM, fetch strobe, slot counters and shift register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      buf_get_word   <= 1'b0;
      buf_rd_pointer <= '0;
      cnt_grp        <= '0;
      frame_sync     <= 1'b0;
      shreg          <= '0;
      bit_cnt        <= '0;
      cur_ptr        <= '0;
      cur_grp        <= '0;
      pend           <= 1'b0;
      prime_cnt      <= 1'b0;
    end else begin
      buf_get_word <= 1'b0;
      case (state)
        IDLE: begin
          prime_cnt <= 1'b0;
          if (run) begin
            state          <= PRIME;
            buf_get_word   <= 1'b1;
            buf_rd_pointer <= '0;
            // After a drain stop the stream resumes with the following phrase.
            cnt_grp        <= nxt_grp;
          end
        end
        PRIME: begin
          prime_cnt <= 1'b1;
          if (prime_cnt) state <= RUN;
        end
        RUN: begin
          if (!run) state <= DRAIN;
        end
        DRAIN: begin
          if (run && !committed) state <= RUN;
        end
        default: state <= IDLE;
      endcase

      if (prefetch) begin
        buf_get_word   <= 1'b1;
        buf_rd_pointer <= nxt_ptr;
        cnt_grp        <= nxt_grp;
        pend           <= 1'b1;
      end

      if (load_now) begin
        shreg      <= data_word;
        bit_cnt    <= '0;
        cur_ptr    <= buf_rd_pointer;
        cur_grp    <= cnt_grp;
        frame_sync <= (buf_rd_pointer == '0) && (cnt_grp == '0);
        pend       <= 1'b0;
      end else if (stop_now) begin
        state      <= IDLE;
        shreg      <= '0;
        bit_cnt    <= '0;
        frame_sync <= 1'b0;
      end else if (shifting && tick) begin
        shreg   <= shreg << 1;
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_m1_frame_sequencer.sv
// Bench for m1_frame_sequencer. A filler model answers each fetch with
// {pointer, group}; expected words are queued by the driver and checked by a
// deserializing monitor. Group length is shortened to 4 so a group wrap fits.
module tb_m1_frame_sequencer;
  localparam int CLK_DIV = 4;
  localparam int GRP_LEN = 4;
  localparam int W       = 12;
  localparam int WORD_CLKS = W * CLK_DIV;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         run = 1'b0;
  logic [W-1:0] data_word = '0;
  logic         buf_get_word;
  logic [6:0]   buf_rd_pointer;
  logic [4:0]   cnt_grp;
  logic         ser_out;
  logic         bit_strobe;
  logic         frame_sync;
  logic         busy;
  logic [1:0]   fsm_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  m1_frame_sequencer #(.CLK_DIV(CLK_DIV), .PHRASE_LEN(128), .GROUP_LEN(GRP_LEN)) dut (
    .clk            (clk),
    .reset          (reset),
    .run            (run),
    .data_word      (data_word),
    .buf_get_word   (buf_get_word),
    .buf_rd_pointer (buf_rd_pointer),
    .cnt_grp        (cnt_grp),
    .ser_out        (ser_out),
    .bit_strobe     (bit_strobe),
    .frame_sync     (frame_sync),
    .busy           (busy),
    .fsm_state      (fsm_state)
  );

  // filler model: registered word {pointer, group} on each fetch strobe
  always @(posedge clk) if (buf_get_word) data_word <= {buf_rd_pointer, cnt_grp};

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: deserialize, compare against exp_q, check bit spacing and frame sync
  logic [W-1:0] sh = '0;
  logic [W-1:0] exp_w;
  int  bit_idx = 0;
  int  words_done = 0;
  int  gap = 0;
  bit  have_prev = 0;
  bit  fs_exp = 0;
  bit  fs_bad = 0;
  int  fs_len = 0;
  int  fs_pulses = 0;
  bit  prev_get = 0;

  always @(negedge clk) begin
    if (!reset || !busy) begin
      bit_idx   = 0;
      have_prev = 0;
      fs_bad    = 0;
    end else if (bit_strobe) begin
      if (have_prev) check("bit_gap", gap, CLK_DIV);
      have_prev = 1;
      gap = 0;
      if (bit_idx == 0) fs_exp = (exp_q.size() > 0) && (exp_q[0] == '0);
      if (frame_sync !== fs_exp) fs_bad = 1;
      sh = {sh[W-2:0], ser_out};
      bit_idx++;
      if (bit_idx == W) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL word: got 'h%0h with no word expected at %0t", sh, $time);
        end else begin
          exp_w = exp_q.pop_front();
          n_tests--;
          check("word", int'(sh), int'(exp_w));
          check("frame_sync_level", int'(fs_bad), 0);
        end
        words_done++;
        bit_idx = 0;
        fs_bad  = 0;
      end
    end
    gap++;

    if (!reset) fs_len = 0;
    else if (frame_sync) fs_len++;
    else if (fs_len > 0) begin
      check("frame_sync_len", fs_len, WORD_CLKS);
      fs_pulses++;
      fs_len = 0;
    end

    if (buf_get_word) check("fetch_spacing", int'(prev_get), 0);
    prev_get = buf_get_word;
  end

  // driver tasks
  task automatic wait_words(input int target);
    int budget;
    budget = (target - words_done) * WORD_CLKS + 400;
    while (words_done < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("wait_words", int'(words_done >= target), 1);
  endtask

  task automatic push_phrase(input int grp, input int count);
    for (int p = 0; p < count; p++) exp_q.push_back({7'(p), 5'(grp)});
  endtask

  task automatic check_first_fetch(input string name);
    int lat;
    lat = 0;
    while (!buf_get_word && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, int'(lat >= 1 && lat <= 2), 1);
    check({name, "_slot"}, {buf_get_word, buf_rd_pointer, cnt_grp}, 13'h1000);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int b;
    b = budget;
    while (busy && b > 0) begin
      @(negedge clk);
      b--;
    end
    check(name, int'(busy), 0);
  endtask

  initial begin
    // reset held with run already high: everything stays zero
    reset = 1'b0;
    run   = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs", {buf_get_word, buf_rd_pointer, cnt_grp, ser_out,
                              bit_strobe, frame_sync, busy}, 0);
    end

    // phrases 0..4, groups 0,1,2,3,0
    for (int ph = 0; ph < 5; ph++) push_phrase(ph % GRP_LEN, 128);
    reset = 1'b1;
    check_first_fetch("first_fetch");

    // 12'h000, 12'h020, 12'h040 then pointer wrap into phrase 1 (group 1)
    wait_words(3);
    wait_words(129);
    // group wrap 3 -> 0 and second frame sync at phrase 4 word 0
    wait_words(4 * 128 + 1);

    // stop request at word 40, cancelled at word 60, reissued at word 80
    wait_words(512 + 40);
    run = 1'b0;
    wait_words(512 + 60);
    run = 1'b1;
    wait_words(512 + 80);
    run = 1'b0;
    wait_idle("drain_stop", 60 * WORD_CLKS);
    check("drain_word_count", words_done, 640);
    check("drain_queue_empty", exp_q.size(), 0);
    check("frame_sync_pulses", fs_pulses, 2);
    check("idle_ser_out", int'(ser_out), 0);
    repeat (10) @(negedge clk);
    check("stays_idle", int'(busy), 0);

    // restart continues with phrase of group 1; abort with reset in word 7, bit 5
    push_phrase(1, 8);
    run = 1'b1;
    wait_words(647);
    begin
      int b;
      b = 100;
      while (bit_idx != 6 && b > 0) begin
        @(negedge clk);
        b--;
      end
      check("reach_bit5", bit_idx, 6);
    end
    reset = 1'b0;
    @(negedge clk);
    check("abort_outputs", {ser_out, busy, bit_strobe, buf_get_word, frame_sync}, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);

    // restart after reset begins at pointer 0, group 0 with frame sync
    push_phrase(0, 128);
    reset = 1'b1;
    check_first_fetch("restart_fetch");
    wait_words(650);
    run = 1'b0;
    wait_idle("final_stop", 130 * WORD_CLKS);
    check("final_word_count", words_done, 647 + 128);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_frame_sync_pulses", fs_pulses, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
